// File: rtl/traffic_junction.sv
// rtl/traffic_junction.sv - multi-approach traffic junction controller with optional pedestrian walk phase (PED_CROSSING_EN)
module traffic_junction #(
    parameter int N_WAY  = 3,
    parameter int CNT_W  = 8,
    parameter int RA_CYC = 2,
    parameter int G_CYC  = 4,
    parameter int A_CYC  = 3,
    parameter int AR_CYC = 1,
    parameter int W_CYC  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             ped_req,
    output logic [N_WAY-1:0] red,
    output logic [N_WAY-1:0] amber,
    output logic [N_WAY-1:0] green,
    output logic             walk
);

    localparam int IDX_W = (N_WAY > 1) ? $clog2(N_WAY) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WAY - 1);

    typedef enum logic [2:0] {
        S_RED_AMBER,
        S_GREEN,
        S_AMBER,
        S_ALL_RED
`ifdef PED_CROSSING_EN
        , S_WALK
`endif
    } state_t;

    // A duration of 0 is treated as a single cycle, so the loaded count floors at 0.
    function automatic logic [CNT_W-1:0] load_val(input int dur);
        return (dur <= 1) ? '0 : CNT_W'(dur - 1);
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [N_WAY-1:0] red_q, red_d;
    logic [N_WAY-1:0] amber_q, amber_d;
    logic [N_WAY-1:0] green_q, green_d;
    logic             walk_q, walk_d;
    logic             pending_q, pending_d;
    logic             timer_done;
    logic [IDX_W-1:0] idx_next;
    logic [N_WAY-1:0] active_sel;

    assign timer_done = (timer_q == '0);
    assign idx_next   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

`ifndef PED_CROSSING_EN
    logic ped_req_unused;
    assign ped_req_unused = ped_req;
`endif

    // Next-state, timer, pending flag and the lamp pattern that goes with the next state.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_done ? timer_q : timer_q - 1'b1;
`ifdef PED_CROSSING_EN
        pending_d  = pending_q | ped_req;
`else
        pending_d  = 1'b0;
`endif
        case (state_q)
            S_RED_AMBER: begin
                if (timer_done) begin
                    state_d = S_GREEN;
                    timer_d = load_val(G_CYC);
                end
            end
            S_GREEN: begin
                // Timer sits at 0 while hold is high; leave on the first cycle it drops.
                if (timer_done && !hold) begin
                    state_d = S_AMBER;
                    timer_d = load_val(A_CYC);
                end
            end
            S_AMBER: begin
                if (timer_done) begin
                    state_d = S_ALL_RED;
                    timer_d = load_val(AR_CYC);
                end
            end
            S_ALL_RED: begin
                if (timer_done) begin
                    idx_d = idx_next;
`ifdef PED_CROSSING_EN
                    if (pending_q) begin
                        state_d   = S_WALK;
                        timer_d   = load_val(W_CYC);
                        pending_d = 1'b0;
                    end else begin
                        state_d = S_RED_AMBER;
                        timer_d = load_val(RA_CYC);
                    end
`else
                    state_d = S_RED_AMBER;
                    timer_d = load_val(RA_CYC);
`endif
                end
            end
`ifdef PED_CROSSING_EN
            S_WALK: begin
                if (timer_done) begin
                    state_d = S_RED_AMBER;
                    timer_d = load_val(RA_CYC);
                end
            end
`endif
            default: begin
                state_d = S_ALL_RED;
                timer_d = load_val(AR_CYC);
            end
        endcase

        active_sel = N_WAY'(1) << idx_d;
        red_d      = '1;
        amber_d    = '0;
        green_d    = '0;
        walk_d     = 1'b0;
        case (state_d)
            S_RED_AMBER: amber_d = active_sel;
            S_GREEN: begin
                red_d   = ~active_sel;
                green_d = active_sel;
            end
            S_AMBER: begin
                red_d   = ~active_sel;
                amber_d = active_sel;
            end
`ifdef PED_CROSSING_EN
            S_WALK:  walk_d = 1'b1;
`endif
            default: ;
        endcase
    end

    // State and registered lamps; reset parks the junction in all-red before approach 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_ALL_RED;
            idx_q     <= LAST_IDX;
            timer_q   <= load_val(AR_CYC);
            pending_q <= 1'b0;
            red_q     <= '1;
            amber_q   <= '0;
            green_q   <= '0;
            walk_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            red_q     <= red_d;
            amber_q   <= amber_d;
            green_q   <= green_d;
            walk_q    <= walk_d;
        end
    end

    assign red   = red_q;
    assign amber = amber_q;
    assign green = green_q;
`ifdef PED_CROSSING_EN
    assign walk  = walk_q;
`else
    assign walk  = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_junction.sv
// tb/tb_traffic_junction.sv - scoreboard testbench for traffic_junction
module tb_traffic_junction;

    localparam int N  = 3;
    localparam int RA = 2;
    localparam int G  = 4;
    localparam int A  = 3;
    localparam int AR = 1;
    localparam int W  = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         hold = 1'b0;
    logic         ped_req = 1'b0;
    logic [N-1:0] red, amber, green;
    logic         walk;

    int tot = 0;
    int bad = 0;

    logic [3*N:0] sb[$];
    logic [3*N:0] exp_v;
    logic [3*N:0] got_v;

    traffic_junction #(
        .N_WAY(N), .CNT_W(8), .RA_CYC(RA), .G_CYC(G), .A_CYC(A), .AR_CYC(AR), .W_CYC(W)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold), .ped_req(ped_req),
        .red(red), .amber(amber), .green(green), .walk(walk)
    );

    always #5 clk = ~clk;

    assign got_v = {red, amber, green, walk};

    // Expected {red, amber, green, walk}: active approach shows ph, others red.
    function automatic logic [3*N:0] exp_vec(input int idx, input logic [2:0] ph, input logic w);
        logic [N-1:0] r, a, g;
        r = '1; a = '0; g = '0;
        r[idx] = ph[2];
        a[idx] = ph[1];
        g[idx] = ph[0];
        return {r, a, g, w};
    endfunction

    task automatic push_n(input logic [3*N:0] v, input int n);
        for (int i = 0; i < n; i++) sb.push_back(v);
    endtask

    task automatic push_approach(input int idx, input int glen);
        push_n(exp_vec(idx, 3'b110, 1'b0), RA);
        push_n(exp_vec(idx, 3'b001, 1'b0), glen);
        push_n(exp_vec(idx, 3'b010, 1'b0), A);
        push_n(exp_vec(idx, 3'b100, 1'b0), AR);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; hold = 1'b0; ped_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    // Safety properties checked every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            tot++;
            if (!$onehot0(amber | green) || (walk && ((amber | green) != '0))) begin
                bad++;
                $display("FAIL safety t=%0t amber=%b green=%b walk=%b required onehot0(amber|green) and walk->none",
                         $time, amber, green, walk);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tot++;
        if (got_v !== {{N{1'b1}}, {N{1'b0}}, {N{1'b0}}, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got=%b required=%b", got_v, {{N{1'b1}}, {(2*N+1){1'b0}}});
        end
    endtask

    task automatic test_round();
        apply_reset();
        for (int r = 0; r < 2; r++)
            for (int a = 0; a < N; a++) push_approach(a, G);
        while (sb.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = sb.pop_front();
            tot++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL round t=%0t got=%b required=%b", $time, got_v, exp_v);
            end
        end
    endtask

    task automatic test_hold();
        apply_reset();
        push_approach(0, 10);
        push_approach(1, G);
        push_approach(2, G);
        // hold high for the 10 samples from the last red+amber cycle to green cycle 9
        for (int n = 1; sb.size() > 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = sb.pop_front();
            tot++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL hold cycle=%0d got=%b required=%b", n, got_v, exp_v);
            end
            hold = (n >= 2 && n <= 11);
        end
        hold = 1'b0;
    endtask

    task automatic test_ped();
        apply_reset();
        push_approach(0, G);
`ifdef PED_CROSSING_EN
        push_n(exp_vec(0, 3'b100, 1'b1), W);
`endif
        push_approach(1, G);
        push_approach(2, G);
        push_approach(0, G);
        for (int n = 1; sb.size() > 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = sb.pop_front();
            tot++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL ped cycle=%0d got=%b required=%b", n, got_v, exp_v);
            end
            ped_req = (n == 3);
        end
        ped_req = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int a = 0; a < N; a++) push_approach(a, G);
        // run into the second amber cycle of approach 2
        for (int n = 1; n <= 28; n++) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = sb.pop_front();
            tot++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL pre_async cycle=%0d got=%b required=%b", n, got_v, exp_v);
            end
        end
        tot++;
        if (amber[2] !== 1'b1) begin
            bad++;
            $display("FAIL mid_amber amber=%b required=100", amber);
        end
        #2 rst = 1'b1;
        #1;
        tot++;
        if (got_v !== {{N{1'b1}}, {(2*N+1){1'b0}}}) begin
            bad++;
            $display("FAIL async_reset got=%b required=%b", got_v, {{N{1'b1}}, {(2*N+1){1'b0}}});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        for (int a = 0; a < N; a++) push_approach(a, G);
        while (sb.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = sb.pop_front();
            tot++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL post_async t=%0t got=%b required=%b", $time, got_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round();
        test_hold();
        test_ped();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
